// File: rtl/count_seq_checker_pkg.sv
// count_pkg: shared definitions for the counter-sequence checker.
//   state_t        - checker FSM states (SEEK, ACQ, LOCK)
//   DEF_*          - default parameter values for the checker and its interface
package count_pkg;

  typedef enum logic [1:0] {
    SEEK = 2'd0,
    ACQ  = 2'd1,
    LOCK = 2'd2
  } state_t;

  localparam int DEF_WIDTH      = 3;
  localparam int DEF_LOCK_CNT   = 2;
  localparam int DEF_MISS_LIMIT = 3;
  localparam int DEF_ERR_W      = 8;

endpackage

// File: rtl/count_seq_checker_if.sv
// count_seq_checker_if: sample bus between an observed counter (master side,
// normally the bench or the counter wrapper) and the checker (slave side).
//   en, q_in, dir                          - sample strobe, observed value, expected direction
//   locked, err_pulse, wrap_pulse, err_count - checker status returned to the master
interface count_seq_checker_if
  import count_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int ERR_W = DEF_ERR_W
);
  logic             en;
  logic [WIDTH-1:0] q_in;
  logic             dir;
  logic             locked;
  logic             err_pulse;
  logic             wrap_pulse;
  logic [ERR_W-1:0] err_count;

  modport master (
    output en, q_in, dir,
    input  locked, err_pulse, wrap_pulse, err_count
  );

  modport slave (
    input  en, q_in, dir,
    output locked, err_pulse, wrap_pulse, err_count
  );
endinterface

// File: rtl/count_seq_checker_sat_counter.sv
// sat_counter: W-bit up counter that sticks at all-ones.
//   clk   - rising-edge clock
//   clr_n - asynchronous active-low clear
//   inc   - increment request for this cycle
//   cnt   - registered count value
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         clr_n,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/count_seq_checker.sv
// count_seq_checker: monitors a free-running up/down counter and checks that
// each strobed sample is the modular successor of the previous one.
//   clk   - rising-edge clock
//   reset - asynchronous active-low reset
//   bus   - slave side of count_seq_checker_if (en/q_in/dir in,
//           locked/err_pulse/wrap_pulse/err_count out, all registered)
module count_seq_checker
  import count_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int LOCK_CNT   = DEF_LOCK_CNT,
  parameter int MISS_LIMIT = DEF_MISS_LIMIT,
  parameter int ERR_W      = DEF_ERR_W
) (
  input logic                clk,
  input logic                reset,
  count_seq_checker_if.slave bus
);

  localparam logic [2:0] LOCK_C = 3'(LOCK_CNT);
  localparam logic [2:0] MISS_C = 3'(MISS_LIMIT);

  state_t           state;
  logic [WIDTH-1:0] last;
  logic [2:0]       good_cnt;
  logic [2:0]       miss_cnt;
  logic             locked_r;
  logic             err_r;
  logic             wrap_r;
  logic [WIDTH-1:0] exp_val;
  logic             match;
  logic             wrap_hit;
  logic             err_inc;

  // Expected successor uses the direction sampled with this strobe, so a
  // direction change is judged against the new direction.
  always_comb begin
    exp_val  = bus.dir ? (last - WIDTH'(1)) : (last + WIDTH'(1));
    match    = (bus.q_in == exp_val);
    wrap_hit = bus.dir ? (bus.q_in == '1) : (bus.q_in == '0);
    err_inc  = bus.en && (state == LOCK) && !match;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= SEEK;
      last     <= '0;
      good_cnt <= '0;
      miss_cnt <= '0;
      locked_r <= 1'b0;
      err_r    <= 1'b0;
      wrap_r   <= 1'b0;
    end else begin
      err_r  <= 1'b0;
      wrap_r <= 1'b0;
      if (bus.en) begin
        // Every strobe resynchronises to the observed value, matched or not.
        last <= bus.q_in;
        case (state)
          SEEK: begin
            good_cnt <= '0;
            state    <= ACQ;
          end
          ACQ: begin
            if (!match) begin
              good_cnt <= '0;
            end else if (good_cnt + 3'd1 == LOCK_C) begin
              good_cnt <= '0;
              miss_cnt <= '0;
              locked_r <= 1'b1;
              state    <= LOCK;
            end else begin
              good_cnt <= good_cnt + 3'd1;
            end
          end
          LOCK: begin
            if (match) begin
              miss_cnt <= '0;
              wrap_r   <= wrap_hit;
            end else begin
              err_r <= 1'b1;
              if (miss_cnt + 3'd1 == MISS_C) begin
                miss_cnt <= '0;
                locked_r <= 1'b0;
                state    <= SEEK;
              end else begin
                miss_cnt <= miss_cnt + 3'd1;
              end
            end
          end
          default: begin
            locked_r <= 1'b0;
            state    <= SEEK;
          end
        endcase
      end
    end
  end

  sat_counter #(.W(ERR_W)) u_err_cnt (
    .clk   (clk),
    .clr_n (reset),
    .inc   (err_inc),
    .cnt   (bus.err_count)
  );

  assign bus.locked     = locked_r;
  assign bus.err_pulse  = err_r;
  assign bus.wrap_pulse = wrap_r;

endmodule

// File: tb/tb_count_seq_checker.sv
module tb_count_seq_checker;

  logic clk = 1'b0;
  logic rst1, rst2;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  count_seq_checker_if #(.WIDTH(3), .ERR_W(8)) b1 ();
  count_seq_checker_if #(.WIDTH(3), .ERR_W(8)) b2 ();

  count_seq_checker #(.WIDTH(3), .LOCK_CNT(2), .MISS_LIMIT(3), .ERR_W(8)) dut1 (
    .clk(clk), .reset(rst1), .bus(b1.slave));
  count_seq_checker #(.WIDTH(3), .LOCK_CNT(2), .MISS_LIMIT(7), .ERR_W(8)) dut2 (
    .clk(clk), .reset(rst2), .bus(b2.slave));

  typedef struct {
    bit rn; bit en; bit dir; int q;
    bit lk; bit ep; bit wp; int ec;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t v(bit rn, bit en, bit dir, int q, bit lk, bit ep, bit wp, int ec);
    vec_t r;
    r.rn = rn; r.en = en; r.dir = dir; r.q = q;
    r.lk = lk; r.ep = ep; r.wp = wp; r.ec = ec;
    return r;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] out1();
    return {21'd0, b1.locked, b1.err_pulse, b1.wrap_pulse, b1.err_count};
  endfunction

  function automatic logic [31:0] out2();
    return {21'd0, b2.locked, b2.err_pulse, b2.wrap_pulse, b2.err_count};
  endfunction

  function automatic logic [31:0] pack(bit lk, bit ep, bit wp, int ec);
    return {21'd0, lk, ep, wp, ec[7:0]};
  endfunction

  // Reference model: checker described as "how many successors in a row have
  // we seen" and "how many misses in a row while tracking", using integer
  // modular arithmetic on the observed sequence.
  int m_tracking[2];  // 0 = no reference yet, 1 = reference held, 2 = tracking
  int m_last[2], m_run[2], m_miss[2], m_err[2];
  bit m_ep[2], m_wp[2];

  task automatic mreset(int k);
    m_tracking[k] = 0; m_last[k] = 0; m_run[k] = 0; m_miss[k] = 0;
    m_err[k] = 0; m_ep[k] = 0; m_wp[k] = 0;
  endtask

  task automatic mstep(int k, bit e, bit d, int q);
    int nxt;
    int lim;
    lim = (k == 0) ? 3 : 7;
    m_ep[k] = 0;
    m_wp[k] = 0;
    if (!e) return;
    nxt = d ? (m_last[k] + 7) % 8 : (m_last[k] + 1) % 8;
    if (m_tracking[k] == 0) begin
      m_tracking[k] = 1;
      m_run[k] = 0;
    end else if (m_tracking[k] == 1) begin
      if (q == nxt) begin
        m_run[k]++;
        if (m_run[k] >= 2) begin
          m_tracking[k] = 2;
          m_miss[k] = 0;
          m_run[k] = 0;
        end
      end else begin
        m_run[k] = 0;
      end
    end else begin
      if (q == nxt) begin
        m_miss[k] = 0;
        m_wp[k] = (q == (d ? 7 : 0));
      end else begin
        m_ep[k] = 1;
        if (m_err[k] < 255) m_err[k]++;
        m_miss[k]++;
        if (m_miss[k] >= lim) begin
          m_tracking[k] = 0;
          m_miss[k] = 0;
        end
      end
    end
    m_last[k] = q;
  endtask

  function automatic logic [31:0] mexp(int k);
    return pack(m_tracking[k] == 2, m_ep[k], m_wp[k], m_err[k]);
  endfunction

  task automatic drive2(bit e, bit d, int q);
    b2.en = e; b2.dir = d; b2.q_in = 3'(q);
    mstep(1, e, d, q);
    tick();
    chk("sat_seq", out2(), mexp(1));
  endtask

  initial begin
    int cur;
    bit d;
    logic [7:0] prev_ec;

    rst1 = 1'b0; rst2 = 1'b0;
    b1.en = 0; b1.dir = 0; b1.q_in = 0;
    b2.en = 0; b2.dir = 0; b2.q_in = 0;
    mreset(0); mreset(1);
    #2;
    chk("reset1", out1(), 32'd0);
    chk("reset2", out2(), 32'd0);
    #10;
    rst1 = 1'b1; rst2 = 1'b1;

    // Up count with wrap
    tv.push_back(v(1,1,0,0, 0,0,0,0));
    tv.push_back(v(1,1,0,1, 0,0,0,0));
    tv.push_back(v(1,1,0,2, 1,0,0,0));
    for (int i = 3; i < 8; i++) tv.push_back(v(1,1,0,i, 1,0,0,0));
    tv.push_back(v(1,1,0,0, 1,0,1,0));
    tv.push_back(v(1,1,0,1, 1,0,0,0));
    // Skipped value, then resync
    tv.push_back(v(1,1,0,2, 1,0,0,0));
    tv.push_back(v(1,1,0,3, 1,0,0,0));
    tv.push_back(v(1,1,0,4, 1,0,0,0));
    tv.push_back(v(1,1,0,6, 1,1,0,1));
    tv.push_back(v(1,1,0,7, 1,0,0,1));
    // Held value repeated until lock drops
    tv.push_back(v(0,0,0,0, 0,0,0,0));
    tv.push_back(v(1,1,0,0, 0,0,0,0));
    tv.push_back(v(1,1,0,1, 0,0,0,0));
    tv.push_back(v(1,1,0,2, 1,0,0,0));
    tv.push_back(v(1,1,0,3, 1,0,0,0));
    tv.push_back(v(1,1,0,4, 1,0,0,0));
    tv.push_back(v(1,1,0,5, 1,0,0,0));
    tv.push_back(v(1,1,0,5, 1,1,0,1));
    tv.push_back(v(1,1,0,5, 1,1,0,2));
    tv.push_back(v(1,1,0,5, 0,1,0,3));
    // Down count with wrap, idle cycle, direction change
    tv.push_back(v(0,0,0,0, 0,0,0,0));
    tv.push_back(v(1,1,1,2, 0,0,0,0));
    tv.push_back(v(1,1,1,1, 0,0,0,0));
    tv.push_back(v(1,1,1,0, 1,0,0,0));
    tv.push_back(v(1,1,1,7, 1,0,1,0));
    tv.push_back(v(1,1,1,6, 1,0,0,0));
    tv.push_back(v(1,0,1,3, 1,0,0,0));
    tv.push_back(v(1,1,1,5, 1,0,0,0));
    tv.push_back(v(1,1,0,6, 1,0,0,0));
    tv.push_back(v(1,1,0,7, 1,0,0,0));
    tv.push_back(v(1,1,1,7, 1,1,0,1));

    for (int i = 0; i < tv.size(); i++) begin
      rst1 = tv[i].rn; b1.en = tv[i].en; b1.dir = tv[i].dir; b1.q_in = 3'(tv[i].q);
      tick();
      chk($sformatf("vec[%0d]", i), out1(), pack(tv[i].lk, tv[i].ep, tv[i].wp, tv[i].ec));
    end

    // Randomized run against the model
    rst1 = 1'b0; b1.en = 0;
    tick();
    rst1 = 1'b1;
    mreset(0);
    cur = 0;
    d = 0;
    for (int i = 0; i < 1500; i++) begin
      int q;
      bit e;
      e = ($urandom % 4) != 0;
      if (($urandom % 16) == 0) d = ~d;
      if (($urandom % 8) == 0) q = int'($urandom % 8);
      else q = d ? (cur + 7) % 8 : (cur + 1) % 8;
      if (e) cur = q;
      b1.en = e; b1.dir = d; b1.q_in = 3'(q);
      mstep(0, e, d, q);
      tick();
      chk($sformatf("rand[%0d]", i), out1(), mexp(0));
    end
    b1.en = 0;

    // Saturation with MISS_LIMIT=7: relock, then seven held samples, repeated
    prev_ec = 0;
    for (int r = 0; r < 45; r++) begin
      drive2(1, 0, 0);
      drive2(1, 0, 1);
      drive2(1, 0, 2);
      for (int j = 0; j < 7; j++) begin
        drive2(1, 0, 2);
        if (b2.err_count < prev_ec) chk("sat_rollover", b2.err_count, prev_ec);
        prev_ec = b2.err_count;
      end
    end
    b2.en = 0;
    chk("sat_final", b2.err_count, 32'd255);

    // Asynchronous reset in the cycle after an error, then relock
    rst1 = 1'b0; b1.en = 0;
    tick();
    rst1 = 1'b1;
    b1.dir = 0;
    b1.en = 1; b1.q_in = 0; tick();
    b1.q_in = 1; tick();
    b1.q_in = 2; tick();
    chk("pre_lock", out1(), pack(1, 0, 0, 0));
    b1.q_in = 2; tick();
    chk("pre_err", out1(), pack(1, 1, 0, 1));
    b1.q_in = 2;
    rst1 = 1'b0;
    #1;
    chk("async_clear", out1(), 32'd0);
    tick();
    chk("held_reset", out1(), 32'd0);
    rst1 = 1'b1;
    b1.q_in = 3; tick();
    chk("relock_seek", out1(), pack(0, 0, 0, 0));
    b1.q_in = 4; tick();
    chk("relock_acq", out1(), pack(0, 0, 0, 0));
    b1.q_in = 5; tick();
    chk("relock_done", out1(), pack(1, 0, 0, 0));
    b1.en = 0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
